// File: rtl/antic_dlist_fetcher.sv
// ANTIC display-list DMA engine: boots the list pointer from the RAM shadow,
// fetches 1/3-byte instructions over a req/ack port and queues them in a FIFO.
module antic_dlist_fetcher #(
  parameter int unsigned       ADDR_W      = 16,
  parameter int unsigned       DATA_W      = 8,
  parameter int unsigned       FIFO_DEPTH  = 4,
  parameter int unsigned       CNT_BITS    = 10,
  parameter logic [ADDR_W-1:0] SHADOW_ADDR = 16'h0230
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              dma_en,
  input  logic              vblank,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              dl_wr_lo,
  input  logic              dl_wr_hi,
  input  logic [DATA_W-1:0] dl_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_ir,
  output logic [ADDR_W-1:0] out_operand,
  output logic [ADDR_W-1:0] dlist_ptr,
  output logic [2:0]        state_dbg
);

  localparam int unsigned PW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CW   = PW + 1;
  localparam int unsigned HI_W = ADDR_W - DATA_W;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    BOOT_LO, BOOT_HI, FETCH_IR, FETCH_LO, FETCH_HI, PUSH, WAIT_VB
  } state_t;

  state_t              state, state_nx;
  logic                req_nx;
  logic [ADDR_W-1:0]   addr_nx, ptr_nx, ptr_inc;
  logic [DATA_W-1:0]   ir_q, ir_nx;
  logic [ADDR_W-1:0]   op_q, op_nx;
  logic [ADDR_W-1:0]   shadow_q, shadow_nx;
  logic                pend_q, pend_nx, have_pend;
  logic [CNT_BITS-1:0] cnt_inc;

  logic [DATA_W-1:0]   fifo_ir [FIFO_DEPTH];
  logic [ADDR_W-1:0]   fifo_op [FIFO_DEPTH];
  logic [PW-1:0]       wr_idx, rd_idx;
  logic [CW-1:0]       count;
  logic                push, pop, has_room;

  function automatic logic needs_operand(input logic [DATA_W-1:0] ir);
    return (ir[3:0] == 4'd1) || (ir[6] && (ir[3:0] >= 4'd2));
  endfunction

  // Only the low CNT_BITS count; the upper bits stay put (1 KB wrap).
  assign cnt_inc = dlist_ptr[CNT_BITS-1:0] + CNT_BITS'(1);
  assign ptr_inc = {dlist_ptr[ADDR_W-1:CNT_BITS], cnt_inc};

  assign has_room    = count < DEPTH_C;
  assign push        = (state == PUSH) && has_room;
  assign out_valid   = count != '0;
  assign pop         = out_valid && out_ready;
  assign out_ir      = fifo_ir[rd_idx];
  assign out_operand = fifo_op[rd_idx];
  assign state_dbg   = state;

  always_comb begin
    state_nx = state;
    req_nx   = mem_req;
    addr_nx  = mem_addr;
    ptr_nx   = dlist_ptr;
    ir_nx    = ir_q;
    op_nx    = op_q;
    // Unwritten byte of a CPU write comes from the live pointer unless a write is already pending.
    shadow_nx = pend_q ? shadow_q : dlist_ptr;
    if (dl_wr_lo) shadow_nx[DATA_W-1:0]      = dl_wdata;
    if (dl_wr_hi) shadow_nx[ADDR_W-1:DATA_W] = HI_W'(dl_wdata);
    have_pend = pend_q | dl_wr_lo | dl_wr_hi;
    pend_nx   = have_pend;

    if (mem_req && mem_ack) req_nx = 1'b0;

    case (state)
      BOOT_LO: begin
        if (!mem_req) begin
          req_nx  = 1'b1;
          addr_nx = SHADOW_ADDR;
        end else if (mem_ack) begin
          ptr_nx[DATA_W-1:0] = mem_data;
          state_nx = BOOT_HI;
        end
      end
      BOOT_HI: begin
        if (!mem_req) begin
          req_nx  = 1'b1;
          addr_nx = SHADOW_ADDR + ADDR_W'(1);
        end else if (mem_ack) begin
          ptr_nx[ADDR_W-1:DATA_W] = HI_W'(mem_data);
          state_nx = FETCH_IR;
        end
      end
      FETCH_IR: begin
        if (mem_req) begin
          if (mem_ack) begin
            ir_nx    = mem_data;
            op_nx    = '0;
            ptr_nx   = ptr_inc;
            state_nx = needs_operand(mem_data) ? FETCH_LO : PUSH;
          end
        end else if (have_pend) begin
          ptr_nx  = shadow_nx;
          pend_nx = 1'b0;
        end else if (dma_en && has_room) begin
          req_nx  = 1'b1;
          addr_nx = dlist_ptr;
        end
      end
      FETCH_LO: begin
        if (!mem_req) begin
          req_nx  = 1'b1;
          addr_nx = dlist_ptr;
        end else if (mem_ack) begin
          op_nx[DATA_W-1:0] = mem_data;
          ptr_nx   = ptr_inc;
          state_nx = FETCH_HI;
        end
      end
      FETCH_HI: begin
        if (!mem_req) begin
          req_nx  = 1'b1;
          addr_nx = dlist_ptr;
        end else if (mem_ack) begin
          op_nx[ADDR_W-1:DATA_W] = HI_W'(mem_data);
          ptr_nx   = ptr_inc;
          state_nx = PUSH;
        end
      end
      PUSH: begin
        if (push) begin
          state_nx = FETCH_IR;
          if (ir_q[3:0] == 4'd1) begin
            ptr_nx = op_q;
            if (ir_q[6]) state_nx = WAIT_VB;
          end
          // A pending CPU write wins over the computed pointer, JMP target included.
          if (have_pend) begin
            ptr_nx  = shadow_nx;
            pend_nx = 1'b0;
          end
        end
      end
      WAIT_VB: begin
        if (have_pend) begin
          ptr_nx   = shadow_nx;
          pend_nx  = 1'b0;
          state_nx = FETCH_IR;
        end else if (vblank) begin
          state_nx = FETCH_IR;
        end
      end
      default: state_nx = BOOT_LO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state     <= BOOT_LO;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      dlist_ptr <= '0;
      ir_q      <= '0;
      op_q      <= '0;
      shadow_q  <= '0;
      pend_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      mem_req   <= req_nx;
      mem_addr  <= addr_nx;
      dlist_ptr <= ptr_nx;
      ir_q      <= ir_nx;
      op_q      <= op_nx;
      shadow_q  <= shadow_nx;
      pend_q    <= pend_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_ir[wr_idx] <= ir_q;
        fifo_op[wr_idx] <= op_q;
        wr_idx <= wr_idx + 1'b1;
      end
      if (pop) rd_idx <= rd_idx + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_antic_dlist_fetcher.sv
// Scoreboard bench for antic_dlist_fetcher: expected request addresses and
// FIFO entries are queued by the stimulus and popped by a negedge monitor.
module tb_antic_dlist_fetcher;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        dma_en = 1'b1;
  logic        vblank = 1'b0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_data = 8'h00;
  logic        dl_wr_lo = 1'b0;
  logic        dl_wr_hi = 1'b0;
  logic [7:0]  dl_wdata = 8'h00;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_ir;
  logic [15:0] out_operand;
  logic [15:0] dlist_ptr;
  logic [2:0]  state_dbg;

  logic [7:0]  ram [0:65535];
  int unsigned ack_delay = 0;
  int unsigned wait_cnt  = 0;
  int          checks    = 0;
  int          failures  = 0;
  int          req_count = 0;
  logic [15:0] exp_req [$];
  logic [23:0] exp_out [$];

  always #5 clk = ~clk;

  antic_dlist_fetcher #(
    .ADDR_W(16), .DATA_W(8), .FIFO_DEPTH(4), .CNT_BITS(10), .SHADOW_ADDR(16'h0230)
  ) dut (
    .clk(clk), .RST(RST), .dma_en(dma_en), .vblank(vblank),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .dl_wr_lo(dl_wr_lo), .dl_wr_hi(dl_wr_hi), .dl_wdata(dl_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_ir(out_ir),
    .out_operand(out_operand), .dlist_ptr(dlist_ptr), .state_dbg(state_dbg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Memory: acknowledges after ack_delay extra cycles, one request at a time.
  always @(negedge clk) begin
    if (!mem_req) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (wait_cnt >= ack_delay) begin
      mem_ack  = 1'b1;
      mem_data = ram[mem_addr];
    end else begin
      wait_cnt++;
    end
  end

  // Monitor: values here are what the next rising edge will see.
  logic        prev_ack = 1'b0;
  logic        in_req   = 1'b0;
  logic [15:0] addr0    = '0;
  always @(negedge clk) begin
    #1;
    if (prev_ack) check("req_drop_after_ack", {31'd0, mem_req}, 32'd0);
    prev_ack = mem_req && mem_ack && !RST;
    if (mem_req) begin
      if (in_req) check("addr_stable", {16'd0, mem_addr}, {16'd0, addr0});
      else begin
        in_req = 1'b1;
        addr0  = mem_addr;
      end
      if (mem_ack && !RST) begin
        req_count++;
        in_req = 1'b0;
        if (exp_req.size() > 0) check("req_addr", {16'd0, mem_addr}, {16'd0, exp_req.pop_front()});
        else begin
          checks++;
          failures++;
          $display("FAIL unexpected_req actual=%h required=none", mem_addr);
        end
      end
    end else begin
      in_req = 1'b0;
    end
    if (out_valid && out_ready && !RST) begin
      if (exp_out.size() > 0) check("out_entry", {8'd0, out_ir, out_operand}, {8'd0, exp_out.pop_front()});
      else begin
        checks++;
        failures++;
        $display("FAIL unexpected_out actual=%h/%h required=none", out_ir, out_operand);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Holds the DUT in reset while the next test is configured.
  task automatic begin_test();
    @(negedge clk);
    RST = 1'b1;
    @(negedge clk);
    exp_req.delete();
    exp_out.delete();
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    vblank   = 1'b0;
    dl_wr_lo = 1'b0;
    dl_wr_hi = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    #2;
    check("rst_mem_req",   {31'd0, mem_req},   32'd0);
    check("rst_mem_addr",  {16'd0, mem_addr},  32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_dlist_ptr", {16'd0, dlist_ptr}, 32'd0);
    @(negedge clk);
    RST = 1'b0;
  endtask

  task automatic drained(input string name);
    check({name, "_req_left"}, exp_req.size(), 32'd0);
    check({name, "_out_left"}, exp_out.size(), 32'd0);
  endtask

  task automatic push_reqs(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) exp_req.push_back(base + 16'(i));
  endtask

  task automatic wait_req_addr(input logic [15:0] a, input int limit, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < limit && !hit; i++) begin
      @(negedge clk);
      #2;
      if (mem_req && mem_addr == a) hit = 1'b1;
    end
    check(name, {31'd0, hit}, 32'd1);
  endtask

  int rc;
  bit seen;

  initial begin
    // Boot, then a plain blank-line instruction followed by JVB.
    begin_test();
    ram[16'h0230] = 8'h00; ram[16'h0231] = 8'h20;
    ram[16'h2000] = 8'h70; ram[16'h2001] = 8'h41; ram[16'h2002] = 8'h00; ram[16'h2003] = 8'h20;
    ack_delay = 0; out_ready = 1'b1; dma_en = 1'b1;
    exp_req.push_back(16'h0230); exp_req.push_back(16'h0231);
    push_reqs(16'h2000, 4);
    exp_out.push_back({8'h70, 16'h0000});
    exp_out.push_back({8'h41, 16'h2000});
    release_reset();
    cycles(40);
    #2;
    drained("boot");
    check("boot_ptr", {16'd0, dlist_ptr}, 32'h2000);

    // LMS with slow memory, JVB wait, then vblank restarts at 2000.
    begin_test();
    ram[16'h0230] = 8'h00; ram[16'h0231] = 8'h20;
    ram[16'h2000] = 8'h42; ram[16'h2001] = 8'h00; ram[16'h2002] = 8'h40;
    ram[16'h2003] = 8'h41; ram[16'h2004] = 8'h00; ram[16'h2005] = 8'h20;
    ack_delay = 3;
    exp_req.push_back(16'h0230); exp_req.push_back(16'h0231);
    push_reqs(16'h2000, 6);
    exp_out.push_back({8'h42, 16'h4000});
    exp_out.push_back({8'h41, 16'h2000});
    release_reset();
    cycles(80);
    #2;
    drained("lms");
    rc = req_count;
    cycles(20);
    #2;
    check("jvb_no_req_count", req_count, rc);
    check("jvb_mem_req_low", {31'd0, mem_req}, 32'd0);
    push_reqs(16'h2000, 6);
    exp_out.push_back({8'h42, 16'h4000});
    exp_out.push_back({8'h41, 16'h2000});
    @(negedge clk); vblank = 1'b1;
    @(negedge clk); vblank = 1'b0;
    cycles(70);
    #2;
    drained("vblank");

    // Pointer wrap inside the operand, then JMP to 1234.
    begin_test();
    ram[16'h0230] = 8'hFE; ram[16'h0231] = 8'h23;
    ram[16'h23FE] = 8'h01; ram[16'h23FF] = 8'h34; ram[16'h2000] = 8'h12;
    ram[16'h1234] = 8'h41; ram[16'h1235] = 8'h34; ram[16'h1236] = 8'h12;
    ack_delay = 0;
    exp_req.push_back(16'h0230); exp_req.push_back(16'h0231);
    exp_req.push_back(16'h23FE); exp_req.push_back(16'h23FF); exp_req.push_back(16'h2000);
    push_reqs(16'h1234, 3);
    exp_out.push_back({8'h01, 16'h1234});
    exp_out.push_back({8'h41, 16'h1234});
    release_reset();
    cycles(50);
    #2;
    drained("wrap");
    check("wrap_ptr", {16'd0, dlist_ptr}, 32'h1234);

    // Backpressure: four entries fill the FIFO, one pop allows one more fetch.
    begin_test();
    ram[16'h0230] = 8'h00; ram[16'h0231] = 8'h20;
    for (int i = 0; i < 16; i++) ram[16'h2000 + i] = 8'h0F;
    out_ready = 1'b0;
    exp_req.push_back(16'h0230); exp_req.push_back(16'h0231);
    push_reqs(16'h2000, 4);
    release_reset();
    cycles(50);
    #2;
    drained("full");
    check("full_mem_req_low", {31'd0, mem_req}, 32'd0);
    check("full_out_valid", {31'd0, out_valid}, 32'd1);
    rc = req_count;
    exp_out.push_back({8'h0F, 16'h0000});
    exp_req.push_back(16'h2004);
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    cycles(30);
    #2;
    drained("one_pop");
    check("one_pop_req_count", req_count, rc + 1);
    check("one_pop_mem_req_low", {31'd0, mem_req}, 32'd0);

    // CPU writes during FETCH_HI of an LMS redirect the next fetch to 3000.
    begin_test();
    ram[16'h0230] = 8'h00; ram[16'h0231] = 8'h20;
    ram[16'h2000] = 8'h42; ram[16'h2001] = 8'h00; ram[16'h2002] = 8'h40;
    ram[16'h3000] = 8'h41; ram[16'h3001] = 8'h00; ram[16'h3002] = 8'h30;
    ack_delay = 3; out_ready = 1'b1;
    exp_req.push_back(16'h0230); exp_req.push_back(16'h0231);
    push_reqs(16'h2000, 3);
    push_reqs(16'h3000, 3);
    exp_out.push_back({8'h42, 16'h4000});
    exp_out.push_back({8'h41, 16'h3000});
    release_reset();
    wait_req_addr(16'h2002, 100, "cpu_reach_fetch_hi");
    @(negedge clk); dl_wr_lo = 1'b1; dl_wdata = 8'h00;
    @(negedge clk); dl_wr_lo = 1'b0; dl_wr_hi = 1'b1; dl_wdata = 8'h30;
    @(negedge clk); dl_wr_hi = 1'b0;
    cycles(60);
    #2;
    drained("cpu_wr");
    check("cpu_wr_ptr", {16'd0, dlist_ptr}, 32'h3000);

    // Reset while a request is outstanding.
    begin_test();
    ram[16'h0230] = 8'h00; ram[16'h0231] = 8'h20;
    for (int i = 0; i < 16; i++) ram[16'h2000 + i] = 8'h70;
    ack_delay = 2; out_ready = 1'b0;
    exp_req.push_back(16'h0230); exp_req.push_back(16'h0231); exp_req.push_back(16'h2000);
    release_reset();
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk); #2;
      if (out_valid) seen = 1'b1;
    end
    check("mid_rst_fifo_filled", {31'd0, seen}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk); #2;
      if (mem_req) seen = 1'b1;
    end
    check("mid_rst_req_seen", {31'd0, seen}, 32'd1);
    @(negedge clk); RST = 1'b1;
    @(negedge clk); #2;
    check("mid_rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_ptr", {16'd0, dlist_ptr}, 32'd0);
    drained("pre_rst");
    exp_req.push_back(16'h0230); exp_req.push_back(16'h0231);
    push_reqs(16'h2000, 4);
    @(negedge clk); RST = 1'b0;
    cycles(80);
    #2;
    drained("post_rst");
    check("post_rst_mem_req_low", {31'd0, mem_req}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
